// File: rtl/instr_encoder_if.sv
// Request channel from the host/debug port into the instruction encoder.
// Ports: in_valid/in_ready handshake plus all instruction field inputs.
interface instr_encoder_if #(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           opcode;
    logic [1:0]           cond;
    logic [REGI_BITS-1:0] ra;
    logic [REGI_BITS-1:0] rb;
    logic [REGI_BITS-1:0] rd;
    logic [VECT_BITS-1:0] va;
    logic [VECT_BITS-1:0] vd;
    logic [7:0]           imm;
    logic [9:0]           jaddr;
    logic [2:0]           sw_org;
    logic [2:0]           sw_dst;

    modport master (
        output in_valid, opcode, cond, ra, rb, rd,
        output va, vd, imm, jaddr, sw_org, sw_dst,
        input  in_ready
    );

    modport slave (
        input  in_valid, opcode, cond, ra, rb, rd,
        input  va, vd, imm, jaddr, sw_org, sw_dst,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs field-level requests into 16-bit instruction words and writes them
// sequentially to instruction memory (one word per 2 cycles).
// Ports: clk, rst_n, start/base_addr control, req (slave request channel),
// mem_we/mem_addr/mem_wdata write port, word_count, done, err, err_code.
module instr_encoder #(
    parameter int MEMO_LINES = 64,
    parameter int ADDR_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    instr_encoder_if.slave       req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [15:0]          mem_wdata,
    output logic [ADDR_BITS:0]   word_count,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code
);
    localparam logic [3:0] OP_CMP   = 4'd0;
    localparam logic [3:0] OP_J     = 4'd1;
    localparam logic [3:0] OP_VXOR  = 4'd2;
    localparam logic [3:0] OP_VXORI = 4'd3;
    localparam logic [3:0] OP_VLD   = 4'd4;
    localparam logic [3:0] OP_VSTR  = 4'd5;
    localparam logic [3:0] OP_VSR   = 4'd6;
    localparam logic [3:0] OP_VSL   = 4'd7;
    localparam logic [3:0] OP_VSWAP = 4'd8;
    localparam logic [3:0] OP_ADD   = 4'd9;
    localparam logic [3:0] OP_SUB   = 4'd10;
    localparam logic [3:0] OP_ADDI  = 4'd11;
    localparam logic [3:0] OP_SUBI  = 4'd12;
    localparam logic [3:0] OP_NOP   = 4'd13;
    localparam logic [3:0] OP_END   = 4'd14;

    localparam logic [ADDR_BITS-1:0] ADDR_MAX = ADDR_BITS'(MEMO_LINES - 1);

    typedef enum logic [2:0] {IDLE, RUN, WRITE, DONE, ERR} state_t;

    state_t               state_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS:0]   cnt_q;
    logic [15:0]          wdata_q;
    logic                 we_q;
    logic                 rdy_q;
    logic                 done_q;
    logic                 err_q;
    logic [1:0]           code_q;
    logic                 end_q;

    logic [15:0]          enc_d;
    logic [1:0]           code_d;

    // Encode the current request; code_d != 0 flags an illegal request.
    always_comb begin
        enc_d       = '0;
        enc_d[3:0]  = req.opcode;
        code_d      = 2'b00;
        case (req.opcode)
            OP_CMP: begin
                enc_d[13:10] = req.ra;
                enc_d[9:6]   = req.rb;
            end
            OP_J: begin
                enc_d[15:14] = req.cond;
                enc_d[13:4]  = req.jaddr;
            end
            OP_VXOR, OP_VSR, OP_VSL: begin
                enc_d[15:14] = req.cond;
                enc_d[12:11] = req.va;
                enc_d[10:9]  = req.vd;
                enc_d[8:5]   = req.ra;
            end
            OP_VXORI: begin
                enc_d[15:14] = req.cond;
                enc_d[12:11] = req.va;
                enc_d[10:9]  = req.vd;
                enc_d[8:4]   = req.imm[4:0];
                if (req.imm > 8'd31) code_d = 2'b10;
            end
            OP_VLD, OP_VSTR: begin
                enc_d[15:14] = req.cond;
                enc_d[13:10] = req.ra;
                // Load names the destination, store names the source.
                enc_d[9:8]   = (req.opcode == OP_VLD) ? req.vd : req.va;
                enc_d[7:5]   = req.imm[2:0];
                if (req.imm > 8'd7) code_d = 2'b10;
            end
            OP_VSWAP: begin
                enc_d[15:14] = req.cond;
                enc_d[13:12] = req.va;
                enc_d[11:10] = req.vd;
                enc_d[9:7]   = req.sw_org;
                enc_d[6:4]   = req.sw_dst;
            end
            OP_ADD, OP_SUB: begin
                enc_d[15:12] = req.ra;
                enc_d[11:8]  = req.rd;
                enc_d[7:4]   = req.rb;
            end
            OP_ADDI, OP_SUBI: begin
                enc_d[15:12] = req.ra;
                enc_d[11:8]  = req.rd;
                enc_d[7:4]   = req.imm[3:0];
                if (req.imm > 8'd15) code_d = 2'b10;
            end
            OP_NOP, OP_END: ;
            default: code_d = 2'b01;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            end_q   <= 1'b0;
        end else if (start) begin
            state_q <= RUN;
            addr_q  <= base_addr;
            cnt_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            end_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (req.in_valid) begin
                        rdy_q <= 1'b0;
                        if (code_d != 2'b00) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            code_q  <= code_d;
                        end else begin
                            state_q <= WRITE;
                            we_q    <= 1'b1;
                            wdata_q <= enc_d;
                            end_q   <= (req.opcode == OP_END);
                        end
                    end
                end
                WRITE: begin
                    we_q  <= 1'b0;
                    cnt_q <= cnt_q + 1'b1;
                    // Address saturates at the last line instead of wrapping.
                    if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
                    if (end_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (addr_q == ADDR_MAX) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        code_q  <= 2'b11;
                    end else begin
                        state_q <= RUN;
                        rdy_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req.in_ready = rdy_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign word_count   = cnt_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = code_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings plus sequences for
// errors, overflow, END handling and asynchronous reset.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  base_addr = '0;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [6:0]  word_count;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int n_chk = 0;
    int n_fail = 0;

    instr_encoder_if #(.REGI_BITS(4), .VECT_BITS(2)) bus ();

    instr_encoder #(.MEMO_LINES(64), .ADDR_BITS(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .req        (bus),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  cond;
        logic [3:0]  ra, rb, rd;
        logic [1:0]  va, vd;
        logic [7:0]  imm;
        logic [9:0]  ja;
        logic [2:0]  org, dst;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(
        input logic [3:0] op, input logic [1:0] cond,
        input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
        input logic [1:0] va, input logic [1:0] vd, input logic [7:0] imm,
        input logic [9:0] ja, input logic [2:0] org, input logic [2:0] dst,
        input logic [15:0] exp);
        vec_t v;
        v.op = op; v.cond = cond; v.ra = ra; v.rb = rb; v.rd = rd;
        v.va = va; v.vd = vd; v.imm = imm; v.ja = ja;
        v.org = org; v.dst = dst; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive fields at a falling edge; returns at the next falling edge,
    // after exactly one rising edge with in_valid high.
    task automatic issue(input vec_t v);
        bus.opcode = v.op;   bus.cond = v.cond;
        bus.ra = v.ra;       bus.rb = v.rb;      bus.rd = v.rd;
        bus.va = v.va;       bus.vd = v.vd;      bus.imm = v.imm;
        bus.jaddr = v.ja;    bus.sw_org = v.org; bus.sw_dst = v.dst;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [5:0] b);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    vec_t nop, endw, bad;

    initial begin
        tbl[0]  = mk(0,  3, 2,  3,  9,  1, 2, 200, 10'h3FF, 7, 7, 16'h08C0);
        tbl[1]  = mk(9,  1, 7,  14, 15, 3, 3, 255, 10'h155, 1, 1, 16'h7FE9);
        tbl[2]  = mk(8,  3, 5,  6,  7,  2, 3, 99,  10'h3FF, 5, 1, 16'hEE98);
        tbl[3]  = mk(3,  1, 15, 15, 15, 0, 3, 30,  10'h3FF, 7, 7, 16'h47E3);
        tbl[4]  = mk(1,  2, 15, 15, 15, 3, 3, 255, 10'h2A5, 7, 7, 16'hAA51);
        tbl[5]  = mk(2,  3, 9,  15, 15, 1, 2, 255, 10'h3FF, 7, 7, 16'hCD22);
        tbl[6]  = mk(6,  1, 4,  15, 15, 2, 1, 255, 10'h3FF, 7, 7, 16'h5286);
        tbl[7]  = mk(7,  0, 15, 0,  0,  3, 0, 0,   10'h000, 0, 0, 16'h19E7);
        tbl[8]  = mk(4,  1, 5,  15, 15, 3, 2, 7,   10'h3FF, 7, 7, 16'h56E4);
        tbl[9]  = mk(5,  2, 12, 15, 15, 1, 3, 3,   10'h3FF, 7, 7, 16'hB165);
        tbl[10] = mk(10, 3, 1,  3,  2,  3, 3, 255, 10'h3FF, 7, 7, 16'h123A);
        tbl[11] = mk(12, 3, 15, 15, 0,  3, 3, 15,  10'h3FF, 7, 7, 16'hF0FC);
        tbl[12] = mk(11, 0, 3,  15, 4,  3, 3, 9,   10'h3FF, 7, 7, 16'h349B);
        tbl[13] = mk(3,  0, 15, 15, 15, 1, 1, 31,  10'h3FF, 7, 7, 16'h0BF3);
        tbl[14] = mk(13, 3, 15, 15, 15, 3, 3, 255, 10'h3FF, 7, 7, 16'h000D);
        nop  = mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h000D);
        endw = mk(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h000E);

        bus.in_valid = 1'b0;
        bus.opcode = '0; bus.cond = '0; bus.ra = '0; bus.rb = '0;
        bus.rd = '0; bus.va = '0; bus.vd = '0; bus.imm = '0;
        bus.jaddr = '0; bus.sw_org = '0; bus.sw_dst = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_status", {done, err, err_code, word_count, mem_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", bus.in_ready, 0);

        // Encoding table, written back to back from address 0.
        do_start(6'd0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("t%0d_ready", i), bus.in_ready, 1);
            issue(tbl[i]);
            chk($sformatf("t%0d_we", i), mem_we, 1);
            chk($sformatf("t%0d_wdata", i), mem_wdata, tbl[i].exp);
            chk($sformatf("t%0d_addr", i), mem_addr, i);
            chk($sformatf("t%0d_rdyw", i), bus.in_ready, 0);
            @(negedge clk);
            chk($sformatf("t%0d_we0", i), mem_we, 0);
            chk($sformatf("t%0d_cnt", i), word_count, i + 1);
        end

        // Immediate range violations.
        bad = mk(11, 0, 1, 1, 1, 0, 0, 16, 0, 0, 0, 0);
        issue(bad);
        chk("addi16_we", mem_we, 0);
        chk("addi16_err", {err, err_code}, 3'b110);
        chk("addi16_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("addi16_hold", {mem_we, err, err_code}, 4'b0110);
        do_start(6'd5);
        chk("restart_clr", {err, err_code, done}, 0);
        chk("restart_addr", mem_addr, 5);
        chk("restart_cnt", word_count, 0);
        bad = mk(4, 0, 1, 1, 1, 0, 0, 8, 0, 0, 0, 0);
        issue(bad);
        chk("vld8_err", {mem_we, err, err_code}, 4'b0110);
        do_start(6'd0);
        bad = mk(3, 0, 1, 1, 1, 0, 0, 32, 0, 0, 0, 0);
        issue(bad);
        chk("vxori32_err", {mem_we, err, err_code}, 4'b0110);

        // Overflow at the last line.
        do_start(6'd62);
        issue(nop);
        chk("ovf_a62", {mem_we, mem_addr}, {1'b1, 6'd62});
        @(negedge clk);
        issue(nop);
        chk("ovf_a63", {mem_we, mem_addr}, {1'b1, 6'd63});
        @(negedge clk);
        chk("ovf_err", {mem_we, done, err, err_code}, 5'b00111);
        chk("ovf_nowrap", mem_addr, 63);
        chk("ovf_cnt", word_count, 2);
        chk("ovf_ready", bus.in_ready, 0);

        // END written at the last line completes cleanly.
        do_start(6'd62);
        issue(nop);
        @(negedge clk);
        issue(endw);
        chk("end63_w", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd63, 16'h000E});
        @(negedge clk);
        chk("end63_st", {done, err, err_code}, 4'b1000);

        // Illegal opcode.
        do_start(6'd0);
        bad = mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(bad);
        chk("op15_err", {mem_we, err, err_code}, 4'b0101);

        // Three NOPs then END, then ignored traffic.
        do_start(6'd0);
        for (int i = 0; i < 3; i++) begin
            issue(nop);
            @(negedge clk);
        end
        issue(endw);
        chk("end_addr", mem_addr, 3);
        @(negedge clk);
        chk("end_cnt", word_count, 4);
        chk("end_done", {done, err, bus.in_ready}, 3'b100);
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("ign_we", mem_we, 0);
        end
        bus.in_valid = 1'b0;
        chk("ign_cnt", word_count, 4);
        chk("ign_done", done, 1);

        // Asynchronous reset while a write is on the bus.
        do_start(6'd9);
        issue(tbl[1]);
        chk("rw_we", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_we0", mem_we, 0);
        chk("rw_out0", {done, err, err_code, word_count, mem_addr, mem_wdata}, 0);
        chk("rw_rdy0", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rw_idle", {bus.in_ready, mem_we, word_count}, 0);
        do_start(6'd0);
        chk("rw_start", bus.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
